// File: rtl/tiny_cpu_pkg.sv
// Shared constants and state type for the tiny RV32 multi-cycle sequencer.
package tiny_cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB
    } seq_state_t;

endpackage

// File: rtl/tiny_tick_gen.sv
// Free-running divider producing a one-cycle tick every 2**TICK_DIV clocks.
module tiny_tick_gen #(
    parameter int unsigned TICK_DIV = 20
) (
    input  logic CLK,
    input  logic RST_N,
    output logic tick
);

    // Keep at least one counter bit so TICK_DIV=0 still elaborates; tick is forced high then.
    localparam int unsigned CNT_W = (TICK_DIV == 0) ? 1 : TICK_DIV;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (TICK_DIV == 0) ? 1'b1 : (&cnt);

endmodule

// File: rtl/tiny_cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control FSM with PC, imem handshake and run/step/halt.
module tiny_cpu_sequencer
    import tiny_cpu_pkg::*;
#(
    parameter int unsigned PC_W     = 4,
    parameter int unsigned XLEN     = tiny_cpu_pkg::XLEN,
    parameter int unsigned TICK_DIV = 20
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            run,
    input  logic            step,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_data,
    output logic [XLEN-1:0] ir,
    output logic            alu_en,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [PC_W-1:0] pc,
    output logic [4:0]      last_wr_reg,
    output logic            halted,
    output logic            illegal,
    output logic [15:0]     retired
);

    seq_state_t state, state_nx;
    logic       tick;
    logic       writes;
    logic       dec_writes;
    logic       dec_nop;

    tiny_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .CLK  (CLK),
        .RST_N(RST_N),
        .tick (tick)
    );

    assign dec_writes = (ir[6:0] == OP_RTYPE) || (ir[6:0] == OP_ITYPE);
    assign dec_nop    = (ir == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        imem_addr = pc;
        alu_en    = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = ir[11:7];
        halted    = 1'b0;
        case (state)
            ST_IDLE: begin
                halted = 1'b1;
                if (!illegal && ((run && tick) || (!run && step))) begin
                    state_nx = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nx = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_nx = (dec_writes || dec_nop) ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC: begin
                alu_en   = 1'b1;
                state_nx = ST_WB;
            end
            ST_WB: begin
                rf_we    = writes && (ir[11:7] != 5'd0);
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ir          <= '0;
            writes      <= 1'b0;
            pc          <= '0;
            last_wr_reg <= '0;
            illegal     <= 1'b0;
            retired     <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_data;
                    end
                end
                ST_DECODE: begin
                    writes <= dec_writes;
                    if (!dec_writes && !dec_nop) begin
                        illegal <= 1'b1;
                    end
                end
                ST_WB: begin
                    if (rf_we) begin
                        last_wr_reg <= rf_waddr;
                    end
                    pc      <= pc + 1'b1;
                    retired <= retired + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tiny_cpu_sequencer.sv
// Randomized transaction-level check of tiny_cpu_sequencer against an instruction-level model.
module tb_tiny_cpu_sequencer;

    localparam int unsigned PC_W = 4;
    localparam int unsigned TDIV = 3;
    localparam int unsigned TPER = 1 << TDIV;

    logic            CLK   = 1'b0;
    logic            RST_N = 1'b1;
    logic            run;
    logic            step;
    logic            imem_ack;
    logic [31:0]     imem_data;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     ir;
    logic            alu_en;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [PC_W-1:0] pc;
    logic [4:0]      last_wr_reg;
    logic            halted;
    logic            illegal;
    logic [15:0]     retired;

    // Free-running instance with TICK_DIV=0 and a zero-wait memory.
    logic            u0_req;
    logic [PC_W-1:0] u0_addr;
    logic [31:0]     u0_ir;
    logic            u0_alu_en;
    logic            u0_rf_we;
    logic [4:0]      u0_rf_waddr;
    logic [PC_W-1:0] u0_pc;
    logic [4:0]      u0_last;
    logic            u0_halted;
    logic            u0_illegal;
    logic [15:0]     u0_retired;

    always #5 CLK = ~CLK;

    tiny_cpu_sequencer #(
        .PC_W    (PC_W),
        .XLEN    (32),
        .TICK_DIV(TDIV)
    ) u_dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .run        (run),
        .step       (step),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .ir         (ir),
        .alu_en     (alu_en),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .pc         (pc),
        .last_wr_reg(last_wr_reg),
        .halted     (halted),
        .illegal    (illegal),
        .retired    (retired)
    );

    tiny_cpu_sequencer #(
        .PC_W    (PC_W),
        .XLEN    (32),
        .TICK_DIV(0)
    ) u_dut0 (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .run        (1'b1),
        .step       (1'b0),
        .imem_req   (u0_req),
        .imem_addr  (u0_addr),
        .imem_ack   (u0_req),
        .imem_data  (32'h00500093),
        .ir         (u0_ir),
        .alu_en     (u0_alu_en),
        .rf_we      (u0_rf_we),
        .rf_waddr   (u0_rf_waddr),
        .pc         (u0_pc),
        .last_wr_reg(u0_last),
        .halted     (u0_halted),
        .illegal    (u0_illegal),
        .retired    (u0_retired)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Edges since reset release; equals the DUT's tick counter modulo TPER.
    int unsigned cyc;
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int unsigned pc_m;
    int unsigned ret_m;
    logic [4:0]  last_m;
    bit          illegal_m;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST_N    = 1'b0;
        run      = 1'b0;
        step     = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("rst_req",     imem_req,    0);
        check("rst_halted",  halted,      1);
        check("rst_pc",      pc,          0);
        check("rst_retired", retired,     0);
        check("rst_illegal", illegal,     0);
        check("rst_last",    last_wr_reg, 0);
        check("rst_alu",     alu_en,      0);
        check("rst_we",      rf_we,       0);
        check("rst_ir",      ir,          0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        pc_m      = 0;
        ret_m     = 0;
        last_m    = '0;
        illegal_m = 1'b0;
    endtask

    function automatic logic [31:0] gen_instr(input bit allow_ill);
        logic [31:0] r;
        int unsigned k;
        logic [4:0]  rd;
        r  = $urandom();
        k  = $urandom_range(0, 9);
        rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        if (k == 0) return 32'h0;
        if (k == 1 && allow_ill) return {r[31:7], 7'b1101111};
        return {r[31:12], rd, (k % 2 == 1) ? 7'b0110011 : 7'b0010011};
    endfunction

    // One instruction from IDLE back to IDLE; expectations follow the instruction-level rules.
    task automatic exec_instr(input logic [31:0] w, input int unsigned waits,
                              input bit use_run, input bit drop_run);
        bit          wr;
        bit          nop;
        bit          exp_we;
        logic [4:0]  rd;
        wr     = (w[6:0] == 7'b0110011) || (w[6:0] == 7'b0010011);
        nop    = (w == 32'h0);
        rd     = w[11:7];
        exp_we = wr && (rd != 5'd0);
        check("idle_halted", halted, 1);
        if (use_run) begin
            run = 1'b1;
            while ((cyc % TPER) != TPER - 1) begin
                step = ($urandom_range(0, 2) == 0);
                next_cycle();
                step = 1'b0;
                check("run_no_start", halted, 1);
                check("run_no_req",   imem_req, 0);
            end
        end else begin
            run  = 1'b0;
            step = 1'b1;
        end
        next_cycle();
        step = 1'b0;
        if (drop_run) run = 1'b0;
        check("fetch_req",  imem_req,  1);
        check("fetch_addr", imem_addr, pc_m);
        check("fetch_busy", halted,    0);
        for (int unsigned i = 0; i < waits; i++) begin
            imem_data = $urandom();
            next_cycle();
            check("wait_req",  imem_req,  1);
            check("wait_addr", imem_addr, pc_m);
        end
        imem_ack  = 1'b1;
        imem_data = w;
        next_cycle();
        imem_ack  = 1'b0;
        imem_data = $urandom();
        check("dec_req", imem_req, 0);
        check("dec_alu", alu_en,   0);
        check("dec_ir",  ir,       w);
        next_cycle();
        if (!wr && !nop) begin
            illegal_m = 1'b1;
            check("ill_halted",  halted,  1);
            check("ill_flag",    illegal, 1);
            check("ill_alu",     alu_en,  0);
            check("ill_pc",      pc,      pc_m);
            check("ill_retired", retired, ret_m);
            return;
        end
        check("exec_alu", alu_en, 1);
        check("exec_we",  rf_we,  0);
        next_cycle();
        check("wb_alu",   alu_en,   0);
        check("wb_we",    rf_we,    exp_we);
        check("wb_waddr", rf_waddr, rd);
        next_cycle();
        if (exp_we) last_m = rd;
        pc_m  = (pc_m + 1) % (1 << PC_W);
        ret_m = (ret_m + 1) & 32'hFFFF;
        check("done_halted",  halted,      1);
        check("done_we",      rf_we,       0);
        check("done_pc",      pc,          pc_m);
        check("done_retired", retired,     ret_m);
        check("done_last",    last_wr_reg, last_m);
        check("done_illegal", illegal,     0);
        if (drop_run) begin
            for (int unsigned i = 0; i < TPER + 2; i++) begin
                next_cycle();
                check("stopped_idle", halted, 1);
            end
        end
    endtask

    task automatic check_blocked();
        for (int unsigned i = 0; i < 2 * TPER; i++) begin
            run  = (i < TPER + 2);
            step = (i % 2 == 1);
            next_cycle();
            check("blk_halted", halted,   1);
            check("blk_req",    imem_req, 0);
        end
        run  = 1'b0;
        step = 1'b0;
        check("blk_illegal", illegal, 1);
        check("blk_pc",      pc,      pc_m);
    endtask

    task automatic reset_in_fetch();
        run  = 1'b0;
        step = 1'b1;
        next_cycle();
        step = 1'b0;
        check("rf_req_before", imem_req, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("rf_req_drop", imem_req, 0);
        check("rf_halted",   halted,   1);
        check("rf_pc",       pc,       0);
        check("rf_retired",  retired,  0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        pc_m      = 0;
        ret_m     = 0;
        last_m    = '0;
        illegal_m = 1'b0;
        check("rf_idle_after", halted, 1);
    endtask

    initial begin
        logic [31:0] w;
        run       = 1'b0;
        step      = 1'b0;
        imem_ack  = 1'b0;
        imem_data = '0;
        #2;
        apply_reset();

        exec_instr(32'h00500093, 0, 1'b0, 1'b0);
        exec_instr(32'h00A00113, 3, 1'b0, 1'b0);
        exec_instr(32'h00000000, 1, 1'b0, 1'b0);
        exec_instr(32'h00000033, 0, 1'b0, 1'b0);

        for (int unsigned i = 0; i < 18; i++) begin
            w = gen_instr(1'b0);
            exec_instr(w, $urandom_range(0, 3), 1'b1, 1'b0);
        end

        for (int unsigned i = 0; i < 40; i++) begin
            w = gen_instr(1'b1);
            exec_instr(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 4) == 0));
            if (illegal_m) begin
                check_blocked();
                apply_reset();
            end
        end

        exec_instr(32'h00300193, 0, 1'b0, 1'b0);
        exec_instr(32'h0000006F, 2, 1'b0, 1'b0);
        check_blocked();
        apply_reset();

        exec_instr(32'h00500093, 1, 1'b0, 1'b0);
        exec_instr(32'h00700213, 0, 1'b1, 1'b0);
        reset_in_fetch();

        apply_reset();
        repeat (49) next_cycle();
        check("u0_retired", u0_retired, 10);
        check("u0_pc",      u0_pc,      10);
        check("u0_last",    u0_last,    1);
        check("u0_halted",  u0_halted,  1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
